// File: rtl/clkinv_div_gen.sv
// Multi-channel programmable clock divider: each channel produces a glitch-free
// divided clock whose ratio and polarity only change at period boundaries.
module clkinv_div_gen #(
    parameter int NCH     = 2,
    parameter int DIVW    = 8,
    parameter int DIV_RST = 0
) (
    input  logic                CLK,
    input  logic                RN,
    input  logic [NCH-1:0]      EN,
    input  logic                CFG_VALID,
    output logic                CFG_READY,
    input  logic [NCH-1:0]      CFG_MASK,
    input  logic [NCH*DIVW-1:0] CFG_DIV,
    input  logic [NCH-1:0]      CFG_INV,
    output logic [NCH-1:0]      ZN,
    output logic [NCH-1:0]      RUN
);

    logic [DIVW-1:0] cnt_r   [NCH];
    logic [DIVW-1:0] div_a_r [NCH];
    logic [DIVW-1:0] div_p_r [NCH];
    logic [NCH-1:0]  ph_r;
    logic [NCH-1:0]  run_r;
    logic [NCH-1:0]  inv_a_r;
    logic [NCH-1:0]  inv_p_r;
    logic [NCH-1:0]  pend_r;
    logic [NCH-1:0]  zn_r;
    logic            ready_r;

    logic [DIVW-1:0] cnt_nx_s   [NCH];
    logic [DIVW-1:0] div_a_nx_s [NCH];
    logic [DIVW-1:0] div_p_nx_s [NCH];
    logic [NCH-1:0]  ph_nx_s;
    logic [NCH-1:0]  run_nx_s;
    logic [NCH-1:0]  inv_a_nx_s;
    logic [NCH-1:0]  inv_p_nx_s;
    logic [NCH-1:0]  pend_nx_s;
    logic [NCH-1:0]  zn_nx_s;
    logic [NCH-1:0]  at_end_s;
    logic [NCH-1:0]  bound_s;
    logic [NCH-1:0]  apply_s;
    logic            xfer_s;

    // Next-state computation for every channel plus the shared config handshake.
    always_comb begin
        xfer_s     = CFG_VALID && ready_r;
        ph_nx_s    = ph_r;
        run_nx_s   = run_r;
        inv_a_nx_s = inv_a_r;
        inv_p_nx_s = inv_p_r;
        pend_nx_s  = pend_r;
        zn_nx_s    = zn_r;
        at_end_s   = '0;
        bound_s    = '0;
        apply_s    = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_nx_s[i]   = cnt_r[i];
            div_a_nx_s[i] = div_a_r[i];
            div_p_nx_s[i] = div_p_r[i];

            at_end_s[i] = (cnt_r[i] == div_a_r[i]);
            bound_s[i]  = run_r[i] && at_end_s[i] && ph_r[i];
            // Pending values land only while idle or exactly at the end of a period.
            apply_s[i]  = pend_r[i] && (!run_r[i] || bound_s[i]);

            if (apply_s[i]) begin
                div_a_nx_s[i] = div_p_r[i];
                inv_a_nx_s[i] = inv_p_r[i];
            end else begin
                div_a_nx_s[i] = div_a_r[i];
                inv_a_nx_s[i] = inv_a_r[i];
            end

            if (!run_r[i]) begin
                cnt_nx_s[i] = '0;
                ph_nx_s[i]  = 1'b0;
                run_nx_s[i] = EN[i];
            end else if (at_end_s[i]) begin
                cnt_nx_s[i] = '0;
                ph_nx_s[i]  = ~ph_r[i];
                run_nx_s[i] = bound_s[i] ? EN[i] : 1'b1;
            end else begin
                cnt_nx_s[i] = cnt_r[i] + DIVW'(1);
                ph_nx_s[i]  = ph_r[i];
                run_nx_s[i] = 1'b1;
            end

            // A transfer is only accepted with nothing pending, so capture never meets apply.
            if (xfer_s && CFG_MASK[i]) begin
                div_p_nx_s[i] = CFG_DIV[i*DIVW +: DIVW];
                inv_p_nx_s[i] = CFG_INV[i];
                pend_nx_s[i]  = 1'b1;
            end else begin
                div_p_nx_s[i] = div_p_r[i];
                inv_p_nx_s[i] = inv_p_r[i];
                pend_nx_s[i]  = apply_s[i] ? 1'b0 : pend_r[i];
            end

            zn_nx_s[i] = ph_nx_s[i] ^ inv_a_nx_s[i];
        end
    end

    // State and output flops; every output is a register clocked by CLK.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i]   <= '0;
                div_a_r[i] <= DIVW'(DIV_RST);
                div_p_r[i] <= '0;
            end
            ph_r    <= '0;
            run_r   <= '0;
            inv_a_r <= '0;
            inv_p_r <= '0;
            pend_r  <= '0;
            zn_r    <= '0;
            ready_r <= 1'b1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i]   <= cnt_nx_s[i];
                div_a_r[i] <= div_a_nx_s[i];
                div_p_r[i] <= div_p_nx_s[i];
            end
            ph_r    <= ph_nx_s;
            run_r   <= run_nx_s;
            inv_a_r <= inv_a_nx_s;
            inv_p_r <= inv_p_nx_s;
            pend_r  <= pend_nx_s;
            zn_r    <= zn_nx_s;
            ready_r <= ~|pend_nx_s;
        end
    end

    assign ZN        = zn_r;
    assign RUN       = run_r;
    assign CFG_READY = ready_r;

endmodule

// File: tb/tb_clkinv_div_gen.sv
// Randomized bench for clkinv_div_gen against a period-position reference model.
module tb_clkinv_div_gen;

    localparam int NCH     = 2;
    localparam int DIVW    = 4;
    localparam int DIV_RST = 0;

    logic                CLK;
    logic                RN;
    logic [NCH-1:0]      EN;
    logic                CFG_VALID;
    logic                CFG_READY;
    logic [NCH-1:0]      CFG_MASK;
    logic [NCH*DIVW-1:0] CFG_DIV;
    logic [NCH-1:0]      CFG_INV;
    logic [NCH-1:0]      ZN;
    logic [NCH-1:0]      RUN;

    int n_tests;
    int n_fail;

    // Reference model: j counts edges since the current period started.
    int m_run  [NCH];
    int m_j    [NCH];
    int m_d    [NCH];
    int m_inv  [NCH];
    int m_pend [NCH];
    int m_dp   [NCH];
    int m_ip   [NCH];
    int m_zn   [NCH];
    int m_ready;

    clkinv_div_gen #(.NCH(NCH), .DIVW(DIVW), .DIV_RST(DIV_RST)) dut (
        .CLK(CLK), .RN(RN), .EN(EN), .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
        .CFG_MASK(CFG_MASK), .CFG_DIV(CFG_DIV), .CFG_INV(CFG_INV), .ZN(ZN), .RUN(RUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_j[i] = 0; m_d[i] = DIV_RST; m_inv[i] = 0;
            m_pend[i] = 0; m_dp[i] = 0; m_ip[i] = 0; m_zn[i] = 0;
        end
        m_ready = 1;
    endtask

    task automatic model_step(input logic [NCH-1:0] en, input logic valid,
                              input logic [NCH-1:0] mask, input logic [NCH*DIVW-1:0] divv,
                              input logic [NCH-1:0] inv);
        int xfer;
        xfer = (valid && m_ready) ? 1 : 0;
        for (int i = 0; i < NCH; i++) begin
            if (m_run[i] == 0) begin
                if (m_pend[i] != 0) begin
                    m_d[i] = m_dp[i]; m_inv[i] = m_ip[i]; m_pend[i] = 0;
                end
                if (en[i]) begin
                    m_run[i] = 1; m_j[i] = 0;
                end
                m_zn[i] = m_inv[i];
            end else begin
                m_j[i] = m_j[i] + 1;
                if (m_j[i] == 2 * (m_d[i] + 1)) begin
                    if (m_pend[i] != 0) begin
                        m_d[i] = m_dp[i]; m_inv[i] = m_ip[i]; m_pend[i] = 0;
                    end
                    m_j[i] = 0;
                    if (!en[i]) m_run[i] = 0;
                end
                m_zn[i] = m_inv[i] ^ ((m_run[i] != 0 && m_j[i] >= m_d[i] + 1) ? 1 : 0);
            end
        end
        if (xfer != 0) begin
            for (int i = 0; i < NCH; i++) begin
                if (mask[i]) begin
                    m_dp[i] = int'(divv[i*DIVW +: DIVW]);
                    m_ip[i] = int'(inv[i]);
                    m_pend[i] = 1;
                end
            end
        end
        m_ready = 1;
        for (int i = 0; i < NCH; i++) if (m_pend[i] != 0) m_ready = 0;
    endtask

    task automatic compare_all();
        logic [NCH-1:0] zn_e;
        logic [NCH-1:0] run_e;
        for (int i = 0; i < NCH; i++) begin
            zn_e[i]  = (m_zn[i] != 0);
            run_e[i] = (m_run[i] != 0);
        end
        check_val("zn", 32'(ZN), 32'(zn_e));
        check_val("run", 32'(RUN), 32'(run_e));
        check_val("cfg_ready", 32'(CFG_READY), 32'(m_ready != 0));
    endtask

    // Called just after a falling edge: drive, advance the model one edge, then check.
    task automatic cycle(input logic [NCH-1:0] en, input logic valid, input logic [NCH-1:0] mask,
                         input logic [NCH*DIVW-1:0] divv, input logic [NCH-1:0] inv);
        EN = en; CFG_VALID = valid; CFG_MASK = mask; CFG_DIV = divv; CFG_INV = inv;
        model_step(en, valid, mask, divv, inv);
        @(negedge CLK);
        compare_all();
    endtask

    task automatic run_cycles(input int n, input logic [NCH-1:0] en);
        for (int k = 0; k < n; k++) cycle(en, 1'b0, '0, '0, '0);
    endtask

    // Asynchronous reset taken between clock edges, checked before the next edge.
    task automatic mid_reset();
        #2 RN = 1'b0;
        #1;
        check_val("rst_zn", 32'(ZN), 32'd0);
        check_val("rst_run", 32'(RUN), 32'd0);
        check_val("rst_ready", 32'(CFG_READY), 32'd1);
        model_reset();
        EN = '0; CFG_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RN = 1'b1;
    endtask

    logic [NCH-1:0]      r_en;
    logic [NCH*DIVW-1:0] r_div;

    initial begin
        n_tests = 0; n_fail = 0;
        RN = 1'b0; EN = '0; CFG_VALID = 1'b0; CFG_MASK = '0; CFG_DIV = '0; CFG_INV = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        compare_all();
        RN = 1'b1;

        run_cycles(10, 2'b01);                           // divide-by-2 from reset ratio
        run_cycles(4, 2'b00);
        cycle(2'b00, 1'b1, 2'b01, 8'h03, 2'b00);         // ch0 ratio 3 while idle
        run_cycles(20, 2'b01);
        cycle(2'b01, 1'b1, 2'b01, 8'h03, 2'b01);         // polarity change while running
        run_cycles(20, 2'b01);
        run_cycles(14, 2'b00);                           // stop mid-period
        cycle(2'b00, 1'b1, 2'b11, 8'h51, 2'b00);         // ch0=1, ch1=5
        run_cycles(15, 2'b11);
        cycle(2'b11, 1'b1, 2'b11, 8'h22, 2'b00);         // both to 2, own boundaries
        run_cycles(20, 2'b11);
        cycle(2'b11, 1'b1, 2'b00, 8'hff, 2'b11);         // empty mask
        run_cycles(3, 2'b11);
        cycle(2'b11, 1'b1, 2'b10, 8'hf0, 2'b00);         // ch1 to max ratio
        run_cycles(80, 2'b11);
        cycle(2'b11, 1'b1, 2'b01, 8'h0f, 2'b01);         // leaves ch0 pending, then reset
        run_cycles(2, 2'b11);
        mid_reset();
        run_cycles(8, 2'b01);

        r_en = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 15) == 0) r_en[i] = ~r_en[i];
                r_div[i*DIVW +: DIVW] = ($urandom_range(0, 3) == 0) ? DIVW'($urandom_range(0, 15))
                                                                    : DIVW'($urandom_range(0, 3));
            end
            cycle(r_en, ($urandom_range(0, 7) == 0), NCH'($urandom_range(0, 3)), r_div,
                  NCH'($urandom_range(0, 3)));
            if (k == 1500) begin
                mid_reset();
                r_en = '0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
